// File: rtl/uart_rx_8bit.sv
// uart_rx_8bit: 8N1 serial receiver with a one-deep valid/ack holding register,
// framing-error and overrun pulses.
module uart_rx_8bit #(
    parameter int CLK_FREQ  = 27000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);
    localparam int BAUD_TICK = CLK_FREQ / BAUD_RATE;
    localparam int HALF_TICK = BAUD_TICK / 2;
    localparam logic [15:0] BAUD_END = 16'(BAUD_TICK - 1);
    localparam logic [15:0] HALF_END = 16'(HALF_TICK - 1);

    typedef enum logic [2:0] {BREAK, IDLE, START, DATA, STOP} state_t;

    state_t      state;
    logic        rx_m;
    logic        rx_s;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= BREAK;
            rx_m      <= 1'b0;
            rx_s      <= 1'b0;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            rx_busy   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_m      <= rx;
            rx_s      <= rx_m;
            cnt       <= cnt + 16'd1;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_valid && rx_ack)
                rx_valid <= 1'b0;
            case (state)
                BREAK: if (rx_s) begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                IDLE: if (!rx_s) begin
                    state   <= START;
                    cnt     <= '0;
                    rx_busy <= 1'b1;
                end
                START: if (cnt == HALF_END) begin
                    // a start bit that is high again at mid-bit is a glitch
                    state   <= rx_s ? IDLE : DATA;
                    rx_busy <= !rx_s;
                    cnt     <= '0;
                    bit_idx <= '0;
                end
                DATA: if (cnt == BAUD_END) begin
                    shift[bit_idx] <= rx_s;
                    bit_idx        <= bit_idx + 3'd1;
                    cnt            <= '0;
                    if (bit_idx == 3'd7)
                        state <= STOP;
                end
                STOP: if (cnt == BAUD_END) begin
                    state     <= rx_s ? IDLE : BREAK;
                    rx_busy   <= 1'b0;
                    cnt       <= '0;
                    frame_err <= !rx_s;
                    overrun   <= rx_s && rx_valid && !rx_ack;
                    // an ack coinciding with the commit frees the slot for the new byte
                    if (rx_s && (!rx_valid || rx_ack)) begin
                        rx_data  <= shift;
                        rx_valid <= 1'b1;
                    end
                end
                default: begin
                    state <= BREAK;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: doc/uart_rx_8bit.md
# uart_rx_8bit

Asynchronous serial receiver for 8N1 frames (1 start, 8 data LSB-first, 1 stop). It is the receive counterpart of the board's 8-bit UART transmitter and shares its `CLK_FREQ`/`BAUD_RATE` parameterisation. It sits between the FPGA `rx` pin and user logic, and presents each received byte in a one-deep holding register with a valid/ack handshake. Framing-error and overrun events are flagged.

## Interface
- `CLK_FREQ`, default 27000000: system clock frequency in Hz.
- `BAUD_RATE`, default 115200: line rate in baud.
- `BAUD_TICK` (localparam) = `CLK_FREQ/BAUD_RATE`, integer division (234 at defaults). Legal range is 4..65535.
- `HALF_TICK` (localparam) = `BAUD_TICK/2`, integer division (117 at defaults).

- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rx` in 1: serial line, asynchronous to `clk`, idle high.
- `rx_ack` in 1: consumer acknowledge; sampled only while `rx_valid`=1, ignored otherwise.
- `rx_data` out 8: last committed byte.
- `rx_valid` out 1: level; high from commit until acknowledged.
- `rx_busy` out 1: high in START, DATA and STOP.
- `frame_err` out 1: one-cycle pulse when a bad stop bit is detected.
- `overrun` out 1: one-cycle pulse when a good byte is dropped because the holding register is full.

## Operation
- **Input synchronizer.** `rx` passes through a 2-flop synchronizer; the second flop output is `rx_s`. Both flops reset to 0.
- **Baud counter.** 16-bit tick counter `cnt`, cleared on every state entry.
- **FSM states.** BREAK, IDLE, START, DATA, STOP.
  - **BREAK:** wait for line idle. Go to IDLE on the first edge with `rx_s`=1.
  - **IDLE:** on `rx_s`=0, go to START.
  - **START:** at `cnt`==`HALF_TICK`-1, sample `rx_s`. If 1, treat it as a glitch and go to IDLE. If 0, go to DATA with `bit_idx`=0.
  - **DATA:** at `cnt`==`BAUD_TICK`-1, shift `rx_s` into bit `bit_idx` of the shift register (LSB first) and increment `bit_idx`. After bit 7, go to STOP.
  - **STOP:** at `cnt`==`BAUD_TICK`-1, sample `rx_s`.
    - If 1 (good stop), commit and go to IDLE.
    - If 0, pulse `frame_err`, discard the byte and go to BREAK.
- **Commit rules:**
  - If `rx_valid`=0: load `rx_data` and set `rx_valid`=1.
  - If `rx_valid`=1 and `rx_ack`=1 in the same cycle: load the new byte; `rx_valid` stays 1; no overrun.
  - If `rx_valid`=1 and `rx_ack`=0: pulse `overrun`; `rx_data` keeps the old byte and the new byte is dropped.
- **Acknowledge.** `rx_ack`=1 with `rx_valid`=1 and no commit clears `rx_valid` on that edge. `rx_data` holds its value after the clear.
- **Concurrency.** The FSM keeps receiving regardless of `rx_valid`. The handshake never stalls reception.

## Timing
- **Reset values:** `rx_data`=0x00, `rx_valid`=0, `rx_busy`=0, `frame_err`=0, `overrun`=0, FSM in BREAK, `cnt`=0, `bit_idx`=0.
- **After reset release** with the line idle high, the FSM reaches IDLE on edge 3: two edges fill the synchronizer, one edge makes the transition.
- **Reset mid-frame:** aborts immediately; the partial byte is lost. Because the FSM restarts in BREAK, a line that is low at release is never mistaken for a start bit.
- **Latency.** Let edge 0 be the first edge at which the synchronizer's first flop captures the start-bit low.
  - START is entered on edge 2.
  - The start bit is sampled on edge 2+`HALF_TICK` (119).
  - Data bits are sampled every `BAUD_TICK` edges after that.
  - Commit, meaning `rx_valid` rises, happens on edge 2+`HALF_TICK`+9·`BAUD_TICK` (2225 at defaults).
  - `frame_err` or `overrun` pulses on that same edge, for exactly one cycle.
- **`rx_busy`** rises on edge 2 and falls on the commit/error edge.
- **Back-to-back frames.** A new start bit whose falling edge arrives at or after the stop-bit sample point is received correctly.
- **Sampling point.** Every bit is sampled within ±1 cycle of its nominal centre for integer `BAUD_TICK`. Tolerated line rate error is ±3%.

## Test plan
- **Single byte.** Send 0xA5 at `BAUD_TICK`=234 cycles per bit, hold `rx_ack`=0 → `rx_valid` rises at edge 2225, `rx_data`=0xA5, no error pulses. Then pulse `rx_ack` → `rx_valid`=0 on the next edge and `rx_data` stays 0xA5.
- **Start glitch.** Drive `rx` low for 50 cycles, then high → START is aborted at edge 119, back to IDLE, `rx_valid`=0 and `rx_busy` falls.
- **Framing error.** Send 0x3C with the stop bit at 0 and hold `rx` low 2000 more cycles → one `frame_err` pulse, `rx_valid` unchanged, FSM stays in BREAK until `rx` returns high. A following 0x81 frame is then received correctly.
- **Overrun and simultaneous ack.**
  - Send 0x11 then 0x22 back-to-back with no ack → `overrun` pulses at the second commit and `rx_data` stays 0x11.
  - Repeat with `rx_ack`=1 exactly on the second commit edge → `rx_data`=0x22, `rx_valid` stays 1, no overrun.
- **Reset mid-frame.** Assert `rst` during data bit 4 of 0xFF while holding `rx` low through release → all outputs at reset values, no spurious frame. Then idle high and send 0x5A → 0x5A received.
- **Parameter sweep.** Rebuild with `CLK_FREQ`=27000000, `BAUD_RATE`=9600 (`BAUD_TICK`=2812). Send 0x00 and 0xFF with the line rate skewed by ±2.5% → both bytes received without error.
